capture_ctrl: RTL and testbench

Acquisition controller for the logic-analyzer core. It sits directly upstream of the sample memory (single-port, 2^width x mem_size, write when mem_we=1, otherwise registered read with 1-cycle latency). It samples probe signals every clock, keeps a circular pre-trigger history, detects a masked pattern trigger, and fills the post-trigger window. It then lets the readout side fetch the capture in chronological order.

---
 rtl/monitor_pkg.sv | 14 +
 rtl/capture_ctrl_trig_match.sv | 13 +
 rtl/capture_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_capture_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/monitor_pkg.sv
// Shared types for the capture controller: acquisition FSM encoding.
package monitor_pkg;

  localparam int state_w = 3;

  typedef enum logic [state_w-1:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    WAIT = 3'd2,
    POST = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage

// File: rtl/capture_ctrl_trig_match.sv
// Masked pattern comparator: hit when every masked bit of samp equals value.
module trig_match #(
  parameter int mem_size = 32
) (
  input  logic [mem_size-1:0] samp,
  input  logic [mem_size-1:0] mask,
  input  logic [mem_size-1:0] value,
  output logic                hit
);

  assign hit = (((samp ^ value) & mask) == {mem_size{1'b0}});

endmodule

// File: rtl/capture_ctrl.sv
// Logic-analyzer acquisition controller: circular pre-trigger history, masked
// trigger, post-trigger fill and chronological readout of the sample memory.
module capture_ctrl
  import monitor_pkg::*;
#(
  parameter int width    = 11,
  parameter int mem_size = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [mem_size-1:0] probe_i,
  input  logic                arm,
  input  logic [width-1:0]    pretrig_i,
  input  logic [mem_size-1:0] trig_mask_i,
  input  logic [mem_size-1:0] trig_value_i,
  input  logic                rd_en,
  input  logic [width-1:0]    rd_idx,
  output logic [mem_size-1:0] mem_dat_o,
  output logic                mem_we,
  output logic [width-1:0]    mem_adr,
  output logic                busy,
  output logic                triggered,
  output logic                done,
  output logic [width-1:0]    trig_adr,
  output logic                rd_valid
);

  localparam int depth = 1 << width;
  localparam logic [width-1:0] max_idx = width'(depth - 1);
  localparam logic [width-1:0] adr_one = {{(width-1){1'b0}}, 1'b1};
  localparam logic [width-1:0] adr_zero = {width{1'b0}};

  state_t               state_r;
  state_t               state_nx_s;
  logic [mem_size-1:0]  samp_r;
  logic [width-1:0]     wr_ptr_r,    wr_ptr_nx_s;
  logic [width-1:0]     count_r,     count_nx_s;
  logic [width-1:0]     pre_q_r,     pre_q_nx_s;
  logic [width-1:0]     trig_adr_r,  trig_adr_nx_s;
  logic [width-1:0]     mem_adr_r,   mem_adr_nx_s;
  logic                 triggered_r, triggered_nx_s;
  logic                 done_r,      done_nx_s;
  logic                 busy_r,      busy_nx_s;
  logic                 mem_we_r,    mem_we_nx_s;
  logic                 rd_pend_r,   rd_pend_nx_s;
  logic                 rd_valid_r;
  logic                 hit_s;
  logic [width-1:0]     post_last_s;
  logic [width-1:0]     rd_adr_s;

  trig_match #(.mem_size(mem_size)) u_trig_match (
    .samp  (samp_r),
    .mask  (trig_mask_i),
    .value (trig_value_i),
    .hit   (hit_s)
  );

  // pretrig_i is width bits wide, so it is already bounded to depth-1.
  assign post_last_s = max_idx - pre_q_r;
  assign rd_adr_s    = trig_adr_r - pre_q_r + rd_idx;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next-state decode
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE, DONE: begin
        if (arm) begin
          state_nx_s = (pretrig_i != adr_zero) ? PRE : WAIT;
        end else begin
          state_nx_s = state_r;
        end
      end
      PRE: begin
        if (count_r == pre_q_r - adr_one) begin
          state_nx_s = WAIT;
        end else begin
          state_nx_s = PRE;
        end
      end
      WAIT: begin
        if (hit_s) begin
          state_nx_s = (post_last_s == adr_zero) ? DONE : POST;
        end else begin
          state_nx_s = WAIT;
        end
      end
      POST: begin
        if (count_r == post_last_s) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = POST;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // Datapath and output next values; outputs are computed one cycle ahead so
  // the registered write strobe lines up with the state it belongs to.
  always_comb begin
    wr_ptr_nx_s    = wr_ptr_r;
    count_nx_s     = count_r;
    pre_q_nx_s     = pre_q_r;
    trig_adr_nx_s  = trig_adr_r;
    triggered_nx_s = triggered_r;
    mem_adr_nx_s   = mem_adr_r;
    rd_pend_nx_s   = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (arm) begin
          wr_ptr_nx_s    = adr_zero;
          count_nx_s     = adr_zero;
          pre_q_nx_s     = pretrig_i;
          triggered_nx_s = 1'b0;
          mem_adr_nx_s   = adr_zero;
        end else if (rd_en && (state_r == DONE)) begin
          mem_adr_nx_s = rd_adr_s;
          rd_pend_nx_s = 1'b1;
        end else begin
          mem_adr_nx_s = mem_adr_r;
        end
      end
      PRE: begin
        wr_ptr_nx_s  = wr_ptr_r + adr_one;
        count_nx_s   = count_r + adr_one;
        mem_adr_nx_s = wr_ptr_r + adr_one;
      end
      WAIT: begin
        wr_ptr_nx_s  = wr_ptr_r + adr_one;
        mem_adr_nx_s = wr_ptr_r + adr_one;
        if (hit_s) begin
          trig_adr_nx_s  = wr_ptr_r;
          triggered_nx_s = 1'b1;
          count_nx_s     = adr_one;
        end else begin
          count_nx_s = count_r;
        end
      end
      POST: begin
        wr_ptr_nx_s  = wr_ptr_r + adr_one;
        count_nx_s   = count_r + adr_one;
        mem_adr_nx_s = wr_ptr_r + adr_one;
      end
      default: begin
        mem_adr_nx_s = mem_adr_r;
      end
    endcase

    case (state_nx_s)
      PRE, WAIT, POST: begin
        busy_nx_s = 1'b1;
        done_nx_s = 1'b0;
      end
      DONE: begin
        busy_nx_s = 1'b0;
        done_nx_s = 1'b1;
      end
      default: begin
        busy_nx_s = 1'b0;
        done_nx_s = 1'b0;
      end
    endcase
    mem_we_nx_s = busy_nx_s;
  end

  // Sample pipeline, datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      samp_r      <= {mem_size{1'b0}};
      wr_ptr_r    <= adr_zero;
      count_r     <= adr_zero;
      pre_q_r     <= adr_zero;
      trig_adr_r  <= adr_zero;
      mem_adr_r   <= adr_zero;
      triggered_r <= 1'b0;
      done_r      <= 1'b0;
      busy_r      <= 1'b0;
      mem_we_r    <= 1'b0;
      rd_pend_r   <= 1'b0;
      rd_valid_r  <= 1'b0;
    end else begin
      samp_r      <= probe_i;
      wr_ptr_r    <= wr_ptr_nx_s;
      count_r     <= count_nx_s;
      pre_q_r     <= pre_q_nx_s;
      trig_adr_r  <= trig_adr_nx_s;
      mem_adr_r   <= mem_adr_nx_s;
      triggered_r <= triggered_nx_s;
      done_r      <= done_nx_s;
      busy_r      <= busy_nx_s;
      mem_we_r    <= mem_we_nx_s;
      rd_pend_r   <= rd_pend_nx_s;
      rd_valid_r  <= rd_pend_r;
    end
  end

  assign mem_dat_o = samp_r;
  assign mem_we    = mem_we_r;
  assign mem_adr   = mem_adr_r;
  assign busy      = busy_r;
  assign triggered = triggered_r;
  assign done      = done_r;
  assign trig_adr  = trig_adr_r;
  assign rd_valid  = rd_valid_r;

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed bench for capture_ctrl (depth 16, 8-bit samples) with a behavioural
// sample memory and a counter as probe source; readout checked via a scoreboard.
module tb_capture_ctrl;

  localparam int W = 4;
  localparam int D = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [D-1:0] cnt = 8'd0;
  logic         arm;
  logic [W-1:0] pretrig;
  logic [D-1:0] trig_mask;
  logic [D-1:0] trig_value;
  logic         rd_en;
  logic [W-1:0] rd_idx;
  logic [D-1:0] mem_dat_o;
  logic         mem_we;
  logic [W-1:0] mem_adr;
  logic         busy, triggered, done, rd_valid;
  logic [W-1:0] trig_adr;

  logic [D-1:0] mem [0:15];
  logic [D-1:0] rdata;
  logic         wr_clr;
  int           wr_cnt;

  int           errors = 0;
  int           checks = 0;
  logic [D-1:0] sb [$];
  logic [D-1:0] p_arm;
  logic [D-1:0] v;

  always #5 clk = ~clk;

  always @(posedge clk) cnt <= cnt + 8'd1;

  // single-port memory: write when mem_we, else registered read
  always @(posedge clk) begin
    if (mem_we === 1'b1) mem[mem_adr] <= mem_dat_o;
    else rdata <= mem[mem_adr];
  end

  always @(posedge clk) begin
    if (wr_clr) wr_cnt <= 0;
    else if (mem_we === 1'b1) wr_cnt <= wr_cnt + 1;
  end

  capture_ctrl #(.width(W), .mem_size(D)) dut (
    .clk(clk), .rst(rst), .probe_i(cnt), .arm(arm), .pretrig_i(pretrig),
    .trig_mask_i(trig_mask), .trig_value_i(trig_value), .rd_en(rd_en),
    .rd_idx(rd_idx), .mem_dat_o(mem_dat_o), .mem_we(mem_we), .mem_adr(mem_adr),
    .busy(busy), .triggered(triggered), .done(done), .trig_adr(trig_adr),
    .rd_valid(rd_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic arm_cap(input logic [W-1:0] pre, input logic [D-1:0] mask, input logic [D-1:0] val);
    p_arm      = cnt;
    pretrig    = pre;
    trig_mask  = mask;
    trig_value = val;
    arm        = 1'b1;
    wr_clr     = 1'b1;
    cyc();
    arm    = 1'b0;
    wr_clr = 1'b0;
    check("arm_busy", 32'(busy), 32'd1);
    check("arm_done_clr", 32'(done), 32'd0);
    check("arm_trig_clr", 32'(triggered), 32'd0);
  endtask

  task automatic wait_done(input string tag, input int limit);
    int n = 0;
    while (done !== 1'b1 && n < limit) begin
      cyc();
      n++;
    end
    check(tag, 32'(done), 32'd1);
  endtask

  // reads idx 0..15 back-to-back; expected sample at idx i is base+i
  task automatic readout(input string tag, input logic [D-1:0] base);
    logic [D-1:0] e;
    for (int k = 0; k < 18; k++) begin
      check({tag, "_rd_valid"}, 32'(rd_valid), (k >= 2) ? 32'd1 : 32'd0);
      if (rd_valid === 1'b1 && sb.size() != 0) begin
        e = sb.pop_front();
        check({tag, "_data"}, 32'(rdata), 32'(e));
      end
      rd_en  = (k < 16);
      rd_idx = W'(k);
      if (k < 16) sb.push_back(base + D'(k));
      cyc();
    end
    rd_en = 1'b0;
    check({tag, "_sb_drain"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; pretrig = '0; trig_mask = '0; trig_value = '0;
    rd_en = 1'b0; rd_idx = '0; wr_clr = 1'b1;
    cyc();
    cyc();
    check("rst_mem_dat", 32'(mem_dat_o), 32'd0);
    rst = 1'b0;
    wr_clr = 1'b0;
    // 1: idle after reset
    repeat (5) cyc();
    check("idle_we_count", 32'(wr_cnt), 32'd0);
    check("idle_mem_we", 32'(mem_we), 32'd0);
    check("idle_mem_adr", 32'(mem_adr), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_triggered", 32'(triggered), 32'd0);
    check("idle_done", 32'(done), 32'd0);
    check("idle_trig_adr", 32'(trig_adr), 32'd0);
    check("idle_rd_valid", 32'(rd_valid), 32'd0);

    // 2: basic pattern trigger
    arm_cap(4'd4, 8'hFF, 8'h30);
    wait_done("t2_done", 200);
    check("t2_triggered", 32'(triggered), 32'd1);
    check("t2_busy", 32'(busy), 32'd0);
    check("t2_mem_we", 32'(mem_we), 32'd0);
    check("t2_trig_adr", 32'(trig_adr), 32'((8'h30 - p_arm) & 8'h0F));
    readout("t2", 8'h2C);

    // 3: zero mask triggers on first sample, exactly depth writes
    arm_cap(4'd0, 8'h00, 8'h00);
    wait_done("t3_done", 100);
    check("t3_writes", 32'(wr_cnt), 32'd16);
    check("t3_trig_adr", 32'(trig_adr), 32'd0);
    readout("t3", p_arm);

    // 4: match during PRE ignored, next lap accepted
    v = cnt + 8'd1;
    arm_cap(4'd6, 8'hFF, v);
    wait_done("t4_done", 600);
    check("t4_trig_adr", 32'(trig_adr), 32'd1);
    readout("t4", v - 8'd6);

    // 5: maximum pre-trigger, read start address wraps
    v = cnt + 8'd20;
    arm_cap(4'd15, 8'hFF, v);
    wait_done("t5_done", 100);
    check("t5_trig_adr", 32'(trig_adr), 32'd4);
    readout("t5", v - 8'd15);

    // 6a: arm while WAIT is ignored
    v = cnt + 8'd10;
    arm_cap(4'd2, 8'hFF, v);
    repeat (3) cyc();
    arm = 1'b1;
    pretrig = 4'd9;
    cyc();
    arm = 1'b0;
    check("t6_rearm_busy", 32'(busy), 32'd1);
    wait_done("t6_done", 100);
    check("t6_trig_adr", 32'(trig_adr), 32'd10);
    readout("t6", v - 8'd2);

    // 6b: reset in the middle of POST
    v = cnt + 8'd5;
    arm_cap(4'd3, 8'hFF, v);
    begin
      int n = 0;
      while (triggered !== 1'b1 && n < 50) begin
        cyc();
        n++;
      end
    end
    check("t6b_triggered", 32'(triggered), 32'd1);
    repeat (2) cyc();
    check("t6b_post_busy", 32'(busy), 32'd1);
    check("t6b_post_we", 32'(mem_we), 32'd1);
    rst = 1'b1;
    cyc();
    check("t6b_rst_busy", 32'(busy), 32'd0);
    check("t6b_rst_we", 32'(mem_we), 32'd0);
    check("t6b_rst_trig", 32'(triggered), 32'd0);
    check("t6b_rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    cyc();
    check("t6b_idle_busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
